// File: rtl/rw_request_scheduler.sv
// Purpose: arbitrates read/write request FIFOs onto one backend command stream (reads first, bounded streaks, bus turnaround).
// Latency: 1 cycle from FIFO head (pop) to registered o_cmd/o_cmd_valid.
// Backpressure: i_cmd_ready=0 holds o_cmd and blocks all pops; turnaround timing is not extended by backpressure.

package rw_request_scheduler_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  id;
  } frontend_command_t;
endpackage

module rw_request_scheduler
  import rw_request_scheduler_pkg::*;
#(
  parameter int unsigned MAX_READ_STREAK  = 8,
  parameter int unsigned MAX_WRITE_STREAK = 8,
  parameter int unsigned T_RTW            = 2,
  parameter int unsigned T_WTR            = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_fifo_empty,
  input  frontend_command_t i_rd_fifo_data,
  output logic              o_rd_fifo_pop,
  input  logic              i_wr_fifo_empty,
  input  frontend_command_t i_wr_fifo_data,
  input  logic              i_write_flush,
  output logic              o_wr_fifo_pop,
  output logic              o_cmd_valid,
  output frontend_command_t o_cmd,
  output logic              o_cmd_is_write,
  input  logic              i_cmd_ready,
  output logic              o_mode_write
);

  localparam logic [7:0] LP_MAX_RD = 8'(MAX_READ_STREAK);
  localparam logic [7:0] LP_MAX_WR = 8'(MAX_WRITE_STREAK);
  localparam logic [3:0] LP_RTW    = 4'(T_RTW - 1);
  localparam logic [3:0] LP_WTR    = 4'(T_WTR - 1);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_R2W   = 2'd1,
    S_WRITE = 2'd2,
    S_W2R   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_rd_streak;
  logic [7:0]        r_wr_streak;
  logic [3:0]        r_tcnt;
  logic              r_cmd_valid;
  frontend_command_t r_cmd;
  logic              r_cmd_is_write;

  logic              w_slot_free;
  logic              w_rd_switch;
  logic              w_wr_switch;
  logic              w_rd_pop;
  logic              w_wr_pop;
  logic              w_mode_write;

  // Output slot can take a new command when empty or being drained this cycle.
  assign w_slot_free = !r_cmd_valid || i_cmd_ready;

  // Leave read mode on a flush (RAW ordering), when reads run dry, or when the read streak starves writes.
  assign w_rd_switch = i_write_flush
                    || (!i_wr_fifo_empty && i_rd_fifo_empty)
                    || (!i_wr_fifo_empty && (r_rd_streak == LP_MAX_RD));

  // Leave write mode once drained, or on the streak limit unless a flush wants a full drain.
  assign w_wr_switch = i_wr_fifo_empty
                    || (!i_write_flush && !i_rd_fifo_empty && (r_wr_streak == LP_MAX_WR));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_READ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: turnaround states exit when the gap counter reaches zero.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_READ:  if (w_rd_switch)   w_state_nxt = S_R2W;
      S_R2W:   if (r_tcnt == '0)  w_state_nxt = S_WRITE;
      S_WRITE: if (w_wr_switch)   w_state_nxt = S_W2R;
      S_W2R:   if (r_tcnt == '0)  w_state_nxt = S_READ;
      default: w_state_nxt = S_READ;
    endcase
  end

  // Output logic: at most one pop, never on a switch cycle, never into a full slot, never in reset.
  always_comb begin
    w_rd_pop     = 1'b0;
    w_wr_pop     = 1'b0;
    w_mode_write = 1'b0;
    case (r_state)
      S_READ:  w_rd_pop = i_rst_n && !w_rd_switch && !i_rd_fifo_empty && w_slot_free;
      S_R2W:   w_mode_write = 1'b1;
      S_WRITE: begin
        w_mode_write = 1'b1;
        w_wr_pop     = i_rst_n && !w_wr_switch && !i_wr_fifo_empty && w_slot_free;
      end
      default: begin
        w_rd_pop = 1'b0;
        w_wr_pop = 1'b0;
      end
    endcase
  end

  // Streak and turnaround counters; streaks saturate, the gap counter reloads on each switch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_streak <= '0;
      r_wr_streak <= '0;
      r_tcnt      <= '0;
    end else begin
      case (r_state)
        S_READ: begin
          if (w_rd_switch) begin
            r_tcnt      <= LP_RTW;
            r_rd_streak <= '0;
          end else if (i_wr_fifo_empty) begin
            r_rd_streak <= '0;
          end else if (w_rd_pop && (r_rd_streak != LP_MAX_RD)) begin
            r_rd_streak <= r_rd_streak + 8'd1;
          end
        end
        S_WRITE: begin
          if (w_wr_switch) begin
            r_tcnt      <= LP_WTR;
            r_wr_streak <= '0;
          end else if (w_wr_pop && !i_rd_fifo_empty && (r_wr_streak != LP_MAX_WR)) begin
            r_wr_streak <= r_wr_streak + 8'd1;
          end
        end
        default: begin
          if (r_tcnt != '0) r_tcnt <= r_tcnt - 4'd1;
        end
      endcase
    end
  end

  // Registered command slot: load on a pop, clear on accept with nothing new, hold under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_valid    <= 1'b0;
      r_cmd          <= '0;
      r_cmd_is_write <= 1'b0;
    end else if (w_rd_pop) begin
      r_cmd_valid    <= 1'b1;
      r_cmd          <= i_rd_fifo_data;
      r_cmd_is_write <= 1'b0;
    end else if (w_wr_pop) begin
      r_cmd_valid    <= 1'b1;
      r_cmd          <= i_wr_fifo_data;
      r_cmd_is_write <= 1'b1;
    end else if (i_cmd_ready) begin
      r_cmd_valid    <= 1'b0;
    end
  end

  assign o_rd_fifo_pop  = w_rd_pop;
  assign o_wr_fifo_pop  = w_wr_pop;
  assign o_cmd_valid    = r_cmd_valid;
  assign o_cmd          = r_cmd;
  assign o_cmd_is_write = r_cmd_is_write;
  assign o_mode_write   = w_mode_write;

endmodule

// File: tb/tb_rw_request_scheduler.sv
// Bench for rw_request_scheduler: models both FIFOs as queues, scoreboards commands per direction,
// and checks issue timing through a per-cycle trace of pops, valid and mode.

module tb_rw_request_scheduler;
  import rw_request_scheduler_pkg::*;

  localparam int C_NONE = 0;
  localparam int C_RD   = 1;
  localparam int C_WR   = 2;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_rd_fifo_empty;
  frontend_command_t i_rd_fifo_data;
  logic              o_rd_fifo_pop;
  logic              i_wr_fifo_empty;
  frontend_command_t i_wr_fifo_data;
  logic              i_write_flush;
  logic              o_wr_fifo_pop;
  logic              o_cmd_valid;
  frontend_command_t o_cmd;
  logic              o_cmd_is_write;
  logic              i_cmd_ready;
  logic              o_mode_write;

  rw_request_scheduler dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_rd_fifo_empty (i_rd_fifo_empty),
    .i_rd_fifo_data  (i_rd_fifo_data),
    .o_rd_fifo_pop   (o_rd_fifo_pop),
    .i_wr_fifo_empty (i_wr_fifo_empty),
    .i_wr_fifo_data  (i_wr_fifo_data),
    .i_write_flush   (i_write_flush),
    .o_wr_fifo_pop   (o_wr_fifo_pop),
    .o_cmd_valid     (o_cmd_valid),
    .o_cmd           (o_cmd),
    .o_cmd_is_write  (o_cmd_is_write),
    .i_cmd_ready     (i_cmd_ready),
    .o_mode_write    (o_mode_write)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  frontend_command_t rd_q[$];
  frontend_command_t wr_q[$];
  frontend_command_t exp_rd[$];
  frontend_command_t exp_wr[$];

  int                n_tests = 0;
  int                n_fail  = 0;
  int                cyc     = 0;
  int                id_ctr  = 0;
  logic              flush_hold = 1'b0;

  int                tr_pop  [0:4095];
  logic              tr_vld  [0:4095];
  logic              tr_mode [0:4095];
  logic              tr_isw  [0:4095];
  frontend_command_t tr_cmd  [0:4095];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    i_rd_fifo_empty = (rd_q.size() == 0);
    i_rd_fifo_data  = (rd_q.size() != 0) ? rd_q[0] : '0;
    i_wr_fifo_empty = (wr_q.size() == 0);
    i_wr_fifo_data  = (wr_q.size() != 0) ? wr_q[0] : '0;
    i_write_flush   = flush_hold && (wr_q.size() != 0);
  endtask

  task automatic push_rd(input int n);
    frontend_command_t c;
    for (int k = 0; k < n; k++) begin
      c.addr = $urandom;
      c.id   = 8'(id_ctr);
      id_ctr++;
      rd_q.push_back(c);
      exp_rd.push_back(c);
    end
    drive_inputs();
  endtask

  task automatic push_wr(input int n);
    frontend_command_t c;
    for (int k = 0; k < n; k++) begin
      c.addr = $urandom;
      c.id   = 8'(id_ctr);
      id_ctr++;
      wr_q.push_back(c);
      exp_wr.push_back(c);
    end
    drive_inputs();
  endtask

  // One clock: observe at the falling edge, then apply FIFO pops just after the rising edge.
  task automatic tick();
    logic rp;
    logic wp;
    logic sf;
    logic bad;
    frontend_command_t e;
    @(negedge i_clk);
    rp  = o_rd_fifo_pop;
    wp  = o_wr_fifo_pop;
    sf  = !o_cmd_valid || i_cmd_ready;
    bad = (rp && wp) || (rp && (rd_q.size() == 0)) || (wp && (wr_q.size() == 0))
       || ((rp || wp) && !sf) || ((rp || wp) && !i_rst_n);
    check("pop_rules", {63'd0, bad}, 64'd0);
    tr_pop[cyc]  = rp ? C_RD : (wp ? C_WR : C_NONE);
    tr_vld[cyc]  = o_cmd_valid;
    tr_mode[cyc] = o_mode_write;
    tr_isw[cyc]  = o_cmd_is_write;
    tr_cmd[cyc]  = o_cmd;
    if (o_cmd_valid && i_cmd_ready) begin
      if (o_cmd_is_write) begin
        if (exp_wr.size() == 0) check("sb_wr_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_wr.pop_front();
          check("sb_wr_cmd", 64'(o_cmd), 64'(e));
        end
      end else begin
        if (exp_rd.size() == 0) check("sb_rd_unexpected", 64'd1, 64'd0);
        else begin
          e = exp_rd.pop_front();
          check("sb_rd_cmd", 64'(o_cmd), 64'(e));
        end
      end
    end
    @(posedge i_clk);
    #1;
    if (rp) void'(rd_q.pop_front());
    if (wp) void'(wr_q.pop_front());
    drive_inputs();
    cyc++;
  endtask

  task automatic drain(input string tag, input int limit);
    int n;
    n = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0 || o_cmd_valid) && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n >= limit), 64'd0);
    check({tag, "_sb_left"}, 64'(exp_rd.size() + exp_wr.size()), 64'd0);
  endtask

  task automatic expect_run(input string tag, inout int at, input int code, input int len);
    for (int k = 0; k < len; k++) begin
      check(tag, 64'(tr_pop[at]), 64'(code));
      at++;
    end
  endtask

  initial begin
    int s;
    int at;
    frontend_command_t held;

    i_rst_n     = 1'b0;
    i_cmd_ready = 1'b1;
    drive_inputs();
    tick();
    check("rst_vld",  64'(o_cmd_valid),    64'd0);
    check("rst_cmd",  64'(o_cmd),          64'd0);
    check("rst_isw",  64'(o_cmd_is_write), 64'd0);
    check("rst_mode", 64'(o_mode_write),   64'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // 1: three reads issue back to back, outputs follow one cycle later.
    s = cyc;
    push_rd(3);
    repeat (6) tick();
    at = s;
    expect_run("t1_pop", at, C_RD, 3);
    expect_run("t1_pop", at, C_NONE, 3);
    check("t1_vld0", 64'(tr_vld[s]), 64'd0);
    for (int k = 1; k <= 3; k++) begin
      check("t1_vld", 64'(tr_vld[s+k]), 64'd1);
      check("t1_isw", 64'(tr_isw[s+k]), 64'd0);
    end
    check("t1_vld4", 64'(tr_vld[s+4]), 64'd0);

    // 2: read streak of 8, switch cycle + 2-cycle R2W, 5 writes, switch cycle + 3-cycle W2R, reads resume.
    s = cyc;
    push_rd(20);
    push_wr(5);
    drain("t2", 300);
    at = s;
    expect_run("t2_pop", at, C_RD, 8);
    expect_run("t2_pop", at, C_NONE, 3);
    expect_run("t2_pop", at, C_WR, 5);
    expect_run("t2_pop", at, C_NONE, 4);
    expect_run("t2_pop", at, C_RD, 12);

    // 3: flush at cycle 10 blocks reads at once and drains 12 writes past the streak limit.
    s = cyc;
    push_rd(30);
    repeat (10) tick();
    flush_hold = 1'b1;
    push_wr(12);
    drain("t3", 400);
    flush_hold = 1'b0;
    drive_inputs();
    at = s;
    expect_run("t3_pop", at, C_RD, 10);
    expect_run("t3_pop", at, C_NONE, 3);
    expect_run("t3_pop", at, C_WR, 12);
    expect_run("t3_pop", at, C_NONE, 4);
    expect_run("t3_pop", at, C_RD, 20);

    // 4: backpressure freezes the slot and pops; issue resumes as ready returns.
    s = cyc;
    push_rd(10);
    push_wr(2);
    held = rd_q[1];
    tick();
    tick();
    i_cmd_ready = 1'b0;
    repeat (4) tick();
    i_cmd_ready = 1'b1;
    tick();
    for (int k = 2; k < 6; k++) begin
      check("t4_nopop", 64'(tr_pop[s+k]), 64'(C_NONE));
      check("t4_vld",   64'(tr_vld[s+k]), 64'd1);
      check("t4_hold",  64'(tr_cmd[s+k]), 64'(held));
    end
    check("t4_resume", 64'(tr_pop[s+6]), 64'(C_RD));
    drain("t4", 300);

    // 5: lone write with reads empty: full round trip through both turnarounds.
    s = cyc;
    push_wr(1);
    repeat (10) tick();
    at = s;
    expect_run("t5_pop", at, C_NONE, 3);
    expect_run("t5_pop", at, C_WR, 1);
    expect_run("t5_pop", at, C_NONE, 5);
    check("t5_mode0", 64'(tr_mode[s]), 64'd0);
    for (int k = 1; k <= 4; k++) check("t5_mode_w", 64'(tr_mode[s+k]), 64'd1);
    for (int k = 5; k <= 8; k++) check("t5_mode_r", 64'(tr_mode[s+k]), 64'd0);
    drain("t5", 50);

    // 6: asynchronous reset in R2W with a held valid command.
    push_rd(2);
    push_wr(1);
    tick();
    tick();
    i_cmd_ready = 1'b0;
    tick();
    check("t6_pre_vld",  64'(o_cmd_valid),  64'd1);
    check("t6_pre_mode", 64'(o_mode_write), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_vld",  64'(o_cmd_valid),    64'd0);
    check("t6_rst_mode", 64'(o_mode_write),   64'd0);
    check("t6_rst_cmd",  64'(o_cmd),          64'd0);
    check("t6_rst_isw",  64'(o_cmd_is_write), 64'd0);
    rd_q.delete();
    wr_q.delete();
    exp_rd.delete();
    exp_wr.delete();
    i_cmd_ready = 1'b1;
    push_rd(1);
    #1;
    check("t6_rst_rdpop", 64'(o_rd_fifo_pop), 64'd0);
    check("t6_rst_wrpop", 64'(o_wr_fifo_pop), 64'd0);
    tick();
    tick();
    i_rst_n = 1'b1;
    s = cyc;
    tick();
    check("t6_post_pop",  64'(tr_pop[s]),  64'(C_RD));
    check("t6_post_mode", 64'(tr_mode[s]), 64'd0);
    drain("t6", 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rw_request_scheduler.md
Name: rw_request_scheduler

Overview:
Sits between the read request FIFO and the write request FIFO on one side and the backend command path on the other. Picks which FIFO to pop and forwards one frontend_command_t per cycle through a registered valid/ready output. Reads have priority. Writes are issued when the write FIFO requests a flush, when reads run dry, or when the anti-starvation streak limit is reached. Every read/write direction switch inserts a programmable bus-turnaround gap.

Parameters:
MAX_READ_STREAK, 8, reads issued back-to-back while writes are pending before a forced switch to writes (1..255)
MAX_WRITE_STREAK, 8, writes issued back-to-back while reads are pending (and no flush) before a switch back to reads (1..255)
T_RTW, 2, idle cycles inserted on a read-to-write switch (1..15)
T_WTR, 3, idle cycles inserted on a write-to-read switch (1..15)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_rd_fifo_empty  input  1  read request FIFO empty
i_rd_fifo_data  input  frontend_command_t  read FIFO head entry
o_rd_fifo_pop  output  1  read FIFO rd_en, combinational
i_wr_fifo_empty  input  1  write request FIFO empty
i_wr_fifo_data  input  frontend_command_t  write FIFO head entry
i_write_flush  input  1  write FIFO flush request (watermark or read-after-write hazard)
o_wr_fifo_pop  output  1  write FIFO rd_en, combinational
o_cmd_valid  output  1  command valid, registered
o_cmd  output  frontend_command_t  command, registered
o_cmd_is_write  output  1  1 = o_cmd came from the write FIFO
i_cmd_ready  input  1  backend accepts o_cmd
o_mode_write  output  1  1 while in S_WRITE or S_R2W

Behaviour:
- Reset (asynchronous, any time, including mid-turnaround): state=S_READ; streak and turnaround counters=0; o_cmd_valid=0; o_cmd=0; o_cmd_is_write=0; o_mode_write=0. Pops are 0 during reset.
- Output slot: slot_free = !o_cmd_valid || i_cmd_ready.
- Issue: on an issue cycle, exactly one pop is asserted and the popped head is loaded into o_cmd with o_cmd_valid=1 on the next edge. Latency is 1 cycle from FIFO head to o_cmd.
- When o_cmd_valid && i_cmd_ready and nothing is issued, o_cmd_valid clears. o_cmd holds its value while valid && !ready.
- No pop is ever asserted when the matching FIFO is empty or when slot_free=0. o_rd_fifo_pop and o_wr_fifo_pop are never high together.
- S_READ:
  - Switch to S_R2W if i_write_flush=1, or (!i_wr_fifo_empty && i_rd_fifo_empty), or (!i_wr_fifo_empty && rd_streak==MAX_READ_STREAK).
  - On the switch cycle, no pop occurs; load tcnt=T_RTW-1; clear rd_streak.
  - Otherwise, pop a read if !i_rd_fifo_empty && slot_free.
  - rd_streak increments on each read pop while !i_wr_fifo_empty. It clears when i_wr_fifo_empty=1 and saturates at MAX_READ_STREAK.
  - i_write_flush=1 blocks read issue in the same cycle. This is the RAW ordering guarantee.
- S_R2W / S_W2R: no pops. tcnt decrements each cycle. At tcnt==0, go to S_WRITE / S_READ.
- S_WRITE:
  - Switch to S_W2R (tcnt=T_WTR-1, wr_streak=0, no pop) if i_wr_fifo_empty=1, or (!i_write_flush && !i_rd_fifo_empty && wr_streak==MAX_WRITE_STREAK).
  - Otherwise, pop a write if slot_free.
  - wr_streak increments per write pop while !i_rd_fifo_empty and saturates.
  - While i_write_flush=1, the streak limit is ignored and the block drains until the write FIFO is empty.
- Both FIFOs empty in S_READ: stay in S_READ, idle. There is no wrap-around concern because counters saturate or reload.
- Backpressure during a turnaround does not extend the turnaround. The held o_cmd remains valid.
- o_mode_write = (state==S_WRITE || state==S_R2W).

Test Plan:
1. Reset with FIFOs empty, then 3 reads loaded, i_cmd_ready=1 -> pops on consecutive cycles; o_cmd_valid high for 3 cycles starting 1 cycle after the first pop; o_cmd_is_write=0.
2. 20 reads and 5 writes pending, no flush, defaults -> 8 reads, 2 idle cycles, 5 writes, 3 idle cycles, then reads resume.
3. Read FIFO non-empty and i_write_flush pulses high at cycle 10 while in S_READ -> no read pop at cycle 10 or after. S_R2W for 2 cycles, then writes drain until i_wr_fifo_empty, even when the count exceeds MAX_WRITE_STREAK. Then S_W2R for 3 cycles, then reads.
4. i_cmd_ready=0 for 4 cycles with both FIFOs non-empty -> o_cmd stable and valid; zero pops; issue resumes the cycle ready returns.
5. Reads empty and 1 write arrives -> S_R2W for 2 cycles, 1 write issued, S_W2R for 3 cycles, back in S_READ with o_mode_write=0.
6. Assert i_rst_n=0 during S_R2W with o_cmd_valid=1 -> o_cmd_valid=0 immediately (asynchronous); state S_READ after release; no pops while reset is active.
